// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one single-cycle 32-bit ALU between two requesters.
// Optional macro ALU_ARBITER_BACK2BACK_EN: accept the next request in the response handshake cycle.
module alu_arbiter #(
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_op,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp0_z,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        rsp1_z,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic        alu_z,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_reg;
   logic        owner_reg;
   logic        prio_reg;
   logic [31:0] op_a_reg;
   logic [31:0] op_b_reg;
   logic [3:0]  op_code_reg;
   logic [31:0] res_reg;
   logic        res_z_reg;

   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_ready;
   logic [1:0]  rsp_valid;
   logic        grant_prio;
   logic        grant_id;
   logic        accept_window;
   logic        accept;
   logic        rsp_hs;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [3:0]  sel_op;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};
   assign rsp_hs    = (state_reg == RESP) && rsp_ready[owner_reg];

`ifdef ALU_ARBITER_BACK2BACK_EN
   // During the response handshake the priority has already flipped to the other requester.
   assign grant_prio    = (state_reg == RESP) ? ~owner_reg : prio_reg;
   assign accept_window = (state_reg == IDLE) || rsp_hs;
`else
   assign grant_prio    = prio_reg;
   assign accept_window = (state_reg == IDLE);
`endif

   assign grant_id = (&req_valid) ? grant_prio : req_valid[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = accept_window && req_valid[gi] && (grant_id == 1'(gi)) && !rst;
      assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi)) && !rst;
   end

   assign accept = |(req_valid & req_ready);
   assign sel_a  = grant_id ? req1_a  : req0_a;
   assign sel_b  = grant_id ? req1_b  : req0_b;
   assign sel_op = grant_id ? req1_op : req0_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         owner_reg   <= 1'b0;
         prio_reg    <= PRIO_INIT;
         op_a_reg    <= '0;
         op_b_reg    <= '0;
         op_code_reg <= '0;
         res_reg     <= '0;
         res_z_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_a_reg    <= sel_a;
                  op_b_reg    <= sel_b;
                  op_code_reg <= sel_op;
                  owner_reg   <= grant_id;
                  state_reg   <= EXEC;
               end
            end
            EXEC: begin
               res_reg   <= alu_result;
               res_z_reg <= alu_z;
               state_reg <= RESP;
            end
            RESP: begin
               if (rsp_hs) begin
                  prio_reg <= ~owner_reg;
                  // accept is only ever high here in the back-to-back build
                  if (accept) begin
                     op_a_reg    <= sel_a;
                     op_b_reg    <= sel_b;
                     op_code_reg <= sel_op;
                     owner_reg   <= grant_id;
                     state_reg   <= EXEC;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req0_ready  = req_ready[0];
   assign req1_ready  = req_ready[1];
   assign rsp0_valid  = rsp_valid[0];
   assign rsp1_valid  = rsp_valid[1];
   assign rsp0_result = res_reg;
   assign rsp1_result = res_reg;
   assign rsp0_z      = res_z_reg;
   assign rsp1_z      = res_z_reg;
   assign alu_a       = op_a_reg;
   assign alu_b       = op_b_reg;
   assign alu_op      = op_code_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed and randomized transactions against a transaction-level model.
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_op, req1_op;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic        rsp0_z, rsp1_z;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic        alu_z;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int model_prio = 0;

`ifdef ALU_ARBITER_BACK2BACK_EN
   localparam int PERIOD = 2;
`else
   localparam int PERIOD = 3;
`endif

   always #5 clk = ~clk;

   alu_arbiter #(.PRIO_INIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_z(rsp0_z),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_z(rsp1_z),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_z(alu_z),
      .busy(busy)
   );

   // Behavioural ALU: both the device's external ALU and the source of expected results.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_op, alu_a, alu_b);
   assign alu_z      = (alu_result == 32'd0);

   function automatic logic rdy(input int p);
      return (p == 0) ? req0_ready : req1_ready;
   endfunction

   function automatic logic rv(input int p);
      return (p == 0) ? rsp0_valid : rsp1_valid;
   endfunction

   function automatic logic [31:0] rres(input int p);
      return (p == 0) ? rsp0_result : rsp1_result;
   endfunction

   function automatic logic rz(input int p);
      return (p == 0) ? rsp0_z : rsp1_z;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      if (p == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
      end
   endtask

   task automatic set_rsp_ready(input int p, input logic v);
      if (p == 0) rsp0_ready = v;
      else rsp1_ready = v;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete operation on port p; the response is held off for 'hold' cycles.
   task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input int hold, input string tag);
      logic [31:0] exp_r;
      logic [31:0] first_res;
      int n;
      exp_r = alu_fn(op, a, b);
      set_rsp_ready(p, hold == 0);
      set_req(p, 1'b1, a, b, op);
      #1;
      n = 0;
      while (!rdy(p) && n < 20) begin
         step();
         n++;
      end
      chk1({tag, "_ready"}, rdy(p), 1'b1);
      chk1({tag, "_other_ready"}, rdy(1 - p), 1'b0);
      step();
      set_req(p, 1'b0, 32'd0, 32'd0, 4'd0);
      chk1({tag, "_exec_novalid"}, rv(p), 1'b0);
      chk1({tag, "_exec_busy"}, busy, 1'b1);
      step();
      first_res = rres(p);
      for (int k = 0; k < hold; k++) begin
         chk1({tag, "_hold_valid"}, rv(p), 1'b1);
         chk32({tag, "_hold_result"}, rres(p), first_res);
         step();
      end
      set_rsp_ready(p, 1'b1);
      #1;
      chk1({tag, "_valid"}, rv(p), 1'b1);
      chk1({tag, "_other_valid"}, rv(1 - p), 1'b0);
      chk32({tag, "_result"}, rres(p), exp_r);
      chk1({tag, "_z"}, rz(p), exp_r == 32'd0);
      $display("txn %s port=%0d op=%0d a=%h b=%h result=%h z=%b", tag, p, op, a, b, rres(p), rz(p));
      step();
      model_prio = 1 - p;
      chk1({tag, "_idle"}, busy, 1'b0);
   endtask

   // Both ports request in the same cycle; the model picks the winner from its own priority.
   task automatic contend(input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1, input string tag);
      logic [31:0] er [2];
      int w;
      int l;
      er[0] = alu_fn(op0, a0, b0);
      er[1] = alu_fn(op1, a1, b1);
      w = model_prio;
      l = 1 - w;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      set_req(0, 1'b1, a0, b0, op0);
      set_req(1, 1'b1, a1, b1, op1);
      #1;
      chk1({tag, "_win_ready"}, rdy(w), 1'b1);
      chk1({tag, "_lose_ready"}, rdy(l), 1'b0);
      step();
      set_req(w, 1'b0, 32'd0, 32'd0, 4'd0);
      chk1({tag, "_lose_ready_exec"}, rdy(l), 1'b0);
      step();
      chk1({tag, "_win_valid"}, rv(w), 1'b1);
      chk32({tag, "_win_result"}, rres(w), er[w]);
      $display("txn %s winner=%0d result=%h", tag, w, rres(w));
      model_prio = l;
`ifdef ALU_ARBITER_BACK2BACK_EN
      chk1({tag, "_lose_ready_b2b"}, rdy(l), 1'b1);
      step();
`else
      step();
      chk1({tag, "_lose_ready_idle"}, rdy(l), 1'b1);
      step();
`endif
      set_req(l, 1'b0, 32'd0, 32'd0, 4'd0);
      step();
      chk1({tag, "_lose_valid"}, rv(l), 1'b1);
      chk32({tag, "_lose_result"}, rres(l), er[l]);
      $display("txn %s second=%0d result=%h", tag, l, rres(l));
      step();
      model_prio = w;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_q [$];
      logic [31:0] first_res;
      int i;
      int nresp;
      int last;
      int n;

      rst = 1'b1;
      set_req(0, 1'b1, 32'd9, 32'd9, 4'd0);
      set_req(1, 1'b1, 32'd9, 32'd9, 4'd0);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      step();
      step();
      chk1("rst_req0_ready", req0_ready, 1'b0);
      chk1("rst_req1_ready", req1_ready, 1'b0);
      chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
      chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_alu_a", alu_a, 32'd0);
      chk32("rst_alu_b", alu_b, 32'd0);
      chk32("rst_alu_op", {28'd0, alu_op}, 32'd0);
      chk32("rst_result", rsp0_result, 32'd0);
      chk1("rst_z", rsp1_z, 1'b0);
      set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
      rst = 1'b0;
      model_prio = 0;
      step();

      // Directed single operations
      run_op(0, 32'd5, 32'd3, 4'd0, 0, "add5_3");
      run_op(1, 32'd7, 32'd7, 4'd1, 0, "sub_zero");

      // Contention: prio 0 now, then prio 1 after a port-0-only op
      contend(32'd1, 32'd1, 4'd0, 32'h0F, 32'hF0, 4'd4, "pair1");
      run_op(0, 32'd2, 32'd2, 4'd2, 0, "and_pre");
      contend(32'd3, 32'd4, 4'd0, 32'd10, 32'd1, 4'd1, "pair2");

      // Backpressure with port 1 waiting
      rsp0_ready = 1'b0;
      set_req(0, 1'b1, 32'h12345677, 32'd1, 4'd0);
      #1;
      chk1("bp_req0_ready", req0_ready, 1'b1);
      step();
      set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_req(1, 1'b1, 32'd6, 32'd2, 4'd1);
      step();
      first_res = rsp0_result;
      chk32("bp_result", first_res, 32'h12345678);
      for (int k = 0; k < 10; k++) begin
         chk1("bp_valid_hold", rsp0_valid, 1'b1);
         chk32("bp_result_hold", rsp0_result, 32'h12345678);
         chk1("bp_req1_blocked", req1_ready, 1'b0);
         step();
      end
      rsp0_ready = 1'b1;
      #1;
      $display("txn bp port=0 result=%h", rsp0_result);
`ifdef ALU_ARBITER_BACK2BACK_EN
      chk1("bp_req1_ready_b2b", req1_ready, 1'b1);
      step();
`else
      chk1("bp_req1_ready_resp", req1_ready, 1'b0);
      step();
      chk1("bp_req1_ready_next", req1_ready, 1'b1);
      step();
`endif
      set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
      step();
      chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
      chk32("bp_rsp1_result", rsp1_result, 32'd4);
      step();
      model_prio = 0;

      // Reset during EXEC discards the operation
      set_req(0, 1'b1, 32'd1, 32'd4, 4'd5);
      #1;
      chk1("rmid_ready", req0_ready, 1'b1);
      step();
      set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
      rst = 1'b1;
      #1;
      chk1("rmid_valid_in_rst", rsp0_valid, 1'b0);
      step();
      rst = 1'b0;
      chk1("rmid_busy", busy, 1'b0);
      chk32("rmid_alu_a", alu_a, 32'd0);
      chk32("rmid_alu_b", alu_b, 32'd0);
      chk32("rmid_alu_op", {28'd0, alu_op}, 32'd0);
      chk32("rmid_result", rsp0_result, 32'd0);
      chk1("rmid_z", rsp0_z, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk1("rmid_no_rsp0", rsp0_valid, 1'b0);
         step();
      end
      model_prio = 0;
      run_op(0, 32'd1, 32'd4, 4'd5, 0, "sll_after_rst");

      // Throughput with a continuous port-0 stream
      i = 0;
      nresp = 0;
      last = -1;
      rsp0_ready = 1'b1;
      set_req(0, 1'b1, 32'd0, 32'd1, 4'd0);
      for (int c = 0; c < 60 && nresp < 8; c++) begin
         #1;
         if (rsp0_valid) begin
            if (exp_q.size() > 0) chk32("tp_result", rsp0_result, exp_q.pop_front());
            else chk1("tp_unexpected_rsp", rsp0_valid, 1'b0);
            if (last >= 0) chk32("tp_spacing", 32'(c - last), 32'(PERIOD));
            $display("txn tp n=%0d cycle=%0d result=%h", nresp, c, rsp0_result);
            last = c;
            nresp++;
         end
         if (req0_ready) exp_q.push_back(32'(i + 1));
         n = int'(req0_ready);
         step();
         if (n != 0) begin
            i++;
            req0_a = 32'(i);
         end
      end
      chk32("tp_count", 32'(nresp), 32'd8);
      set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
      n = 0;
      while (busy && n < 10) begin
         step();
         n++;
      end
      chk1("tp_drain", busy, 1'b0);
      model_prio = 1;

      // Randomized traffic
      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            contend($urandom, $urandom, 4'($urandom_range(0, 15)),
                    $urandom, $urandom, 4'($urandom_range(0, 15)), "rnd_pair");
         end else begin
            run_op(int'($urandom_range(0, 1)), $urandom, 32'($urandom_range(0, 40)),
                   4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rnd_op");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
